// File: rtl/pad_cond_pkg.sv
// Shared constants and helpers for pad-input conditioning blocks.
//   clog2            : ceiling log2, usable in parameter expressions
//   SYNC_STAGES_MIN  : shallowest legal synchronizer
//   SYNC_STAGES_MAX  : deepest legal synchronizer
//   DEBOUNCE_DEFAULT : default consecutive-sample count for the debounce filter
package pad_cond_pkg;

  localparam int SYNC_STAGES_MIN  = 2;
  localparam int SYNC_STAGES_MAX  = 4;
  localparam int DEBOUNCE_DEFAULT = 4;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pad_sync_chain.sv
// N-flop metastability synchronizer for a single asynchronous bit.
//   CLK : capture clock, rising edge
//   RST : synchronous active-high reset, loads RESET_VAL into every stage
//   D   : asynchronous input
//   Q   : synchronized output (last stage)
module pad_sync_chain
  import pad_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_depth
    $error("pad_sync_chain: SYNC_STAGES out of legal range");
  end

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], D};
    end
  end

  assign Q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: synchronizer, consecutive-sample debounce, edge strobes.
//   CLK      : single clock, rising edge
//   RST      : synchronous active-high reset
//   EN       : filter enable; low freezes the accepted level
//   DATA_IN  : asynchronous pin level from the pad buffer
//   DATA_OUT : debounced, synchronized level
//   RISE     : one-cycle strobe on the first cycle DATA_OUT shows 1 after 0
//   FALL     : one-cycle strobe on the first cycle DATA_OUT shows 0 after 1
//   BUSY     : a candidate level change is being qualified
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic DATA_IN,
  output logic DATA_OUT,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) > 1) ? clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  pad_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (RESET_VAL)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (DATA_IN),
    .Q  (sync_q)
  );

  // cnt counts differing samples already seen; the sample that finds
  // cnt == CNT_LAST is the DEBOUNCE_CYCLES-th and commits the new level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_OUT <= RESET_VAL;
      cnt      <= '0;
      RISE     <= 1'b0;
      FALL     <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      if (!EN) begin
        cnt <= '0;
      end else if (sync_q == DATA_OUT) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        DATA_OUT <= sync_q;
        cnt      <= '0;
        RISE     <= sync_q;
        FALL     <= ~sync_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign BUSY = (cnt != '0);

endmodule

// File: tb/tb_pad_input_conditioner.sv
module tb_pad_input_conditioner;

  localparam int S  = 2;
  localparam int DC = 4;
  localparam bit RV = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  int compared   = 0;
  int mismatched = 0;
  int dut_rises  = 0;
  int dut_falls  = 0;
  bit started    = 1'b0;

  always #5 clk = ~clk;

  pad_input_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VAL      (RV)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .DATA_IN (din),
    .DATA_OUT(dout),
    .RISE    (rise),
    .FALL    (fall),
    .BUSY    (busy)
  );

  // Reference model: the pin is seen S edges late; the accepted level flips
  // once DC consecutive enabled samples disagree with it.
  typedef struct packed {
    bit dout;
    bit rise;
    bit fall;
    bit busy;
  } exp_t;

  exp_t sb[$];
  bit   delay_line[$];
  bit   level;
  int   streak;

  always @(posedge clk) begin
    bit s, r, f;
    r = 1'b0;
    f = 1'b0;
    if (rst) begin
      delay_line.delete();
      for (int i = 0; i < S; i++) delay_line.push_back(RV);
      level  = RV;
      streak = 0;
    end else begin
      s = delay_line[S-1];
      if (!en || s == level) begin
        streak = 0;
      end else begin
        streak = streak + 1;
        if (streak == DC) begin
          level  = s;
          r      = s;
          f      = !s;
          streak = 0;
        end
      end
      delay_line.push_front(din);
      void'(delay_line.pop_back());
    end
    sb.push_back('{dout: level, rise: r, fall: f, busy: (streak != 0)});
    started = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output set.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_empty: got 0 entries expected >=1 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("data_out", int'(dout), int'(e.dout));
        check("rise",     int'(rise), int'(e.rise));
        check("fall",     int'(fall), int'(e.fall));
        check("busy",     int'(busy), int'(e.busy));
        check("rise_and_fall", int'(rise && fall), 0);
      end
      if (rise) dut_rises++;
      if (fall) dut_falls++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r0, f0;

    // 1. reset with pin high, then release
    din = 1'b1;
    cycles(3);
    rst = 1'b0;
    r0 = dut_rises;
    cycles(8);
    check("reset_release_one_rise", dut_rises - r0, 1);

    // 2. clean steps
    din = 1'b0;
    cycles(10);
    din = 1'b1;
    cycles(10);
    din = 1'b0;
    cycles(10);

    // 3. glitch rejection, then a just-long-enough pulse
    r0 = dut_rises;
    din = 1'b1; cycles(3);
    din = 1'b0; cycles(8);
    check("glitch_no_rise", dut_rises - r0, 0);
    din = 1'b1; cycles(4);
    din = 1'b0; cycles(10);
    check("pulse4_one_rise", dut_rises - r0, 1);

    // 4. chatter then settle high
    r0 = dut_rises;
    f0 = dut_falls;
    for (int i = 0; i < 20; i++) begin
      din = ~din;
      cycles(2);
    end
    din = 1'b1;
    cycles(10);
    check("chatter_one_rise", dut_rises - r0, 1);
    check("chatter_no_fall",  dut_falls - f0, 1 - 1);
    din = 1'b0;
    cycles(10);

    // 5. EN gating
    en = 1'b0;
    din = 1'b1;
    cycles(10);
    check("en_low_hold", int'(dout), 0);
    en = 1'b1;
    cycles(6);
    din = 1'b0;
    cycles(10);

    // 6. reset mid-count
    r0 = dut_rises;
    din = 1'b1;
    cycles(4);
    check("busy_mid_count", int'(busy), 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(1);
    check("no_rise_after_mid_reset", dut_rises - r0, 0);
    cycles(10);
    check("requalified_after_reset", dut_rises - r0, 1);

    // randomized run: variable hold lengths, EN drops, occasional reset
    for (int i = 0; i < 400; i++) begin
      din = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
      cycles(int'($urandom_range(1, 7)));
    end
    rst = 1'b0;
    en  = 1'b1;
    cycles(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
